// File: rtl/mem_seq_pkg.sv
// Shared encodings for the memory-operation sequencer: FSM states, bus owner and RAM direction.
package mem_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic OWNER_FETCH = 1'b0;
  localparam logic OWNER_DATA  = 1'b1;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/mem_seq_watchdog.sv
// ACCESS-phase wait counter; expired flags the last allowed cycle without MOC.
// Only instantiated when MEM_SEQ_TIMEOUT_EN is defined.
module mem_seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Count is zero in the first ACCESS cycle, so this is the TIMEOUT_CYCLES-th one.
  assign expired = (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_op_sequencer.sv
// Multicycle MAR/MDR/RAM sequencer arbitrating fetch and data requests with MOC handshake.
// Optional ACCESS timeout with sticky timeout_err is enabled by defining MEM_SEQ_TIMEOUT_EN.
module mem_op_sequencer #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic fetch_req,
  input  logic data_req,
  input  logic data_rw,
  input  logic mem_moc,
  input  logic err_clr,
  output logic addr_sel,
  output logic mar_load,
  output logic mem_enable,
  output logic mem_rw,
  output logic mdr_load,
  output logic ir_load,
  output logic fetch_done,
  output logic data_done,
  output logic busy,
  output logic timeout_err
);

  import mem_seq_pkg::*;

  state_t state;
  state_t state_next;
  logic   owner;
  logic   rw;
  logic   timeout_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      owner <= OWNER_FETCH;
      rw    <= RW_READ;
    end else begin
      state <= state_next;
      // Data has fixed priority; fetches are always reads.
      if (state == ST_IDLE) begin
        if (data_req) begin
          owner <= OWNER_DATA;
          rw    <= data_rw;
        end else if (fetch_req) begin
          owner <= OWNER_FETCH;
          rw    <= RW_READ;
        end
      end
    end
  end

`ifdef MEM_SEQ_TIMEOUT_EN
  logic expired;

  mem_seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == ST_ADDR),
    .enable (state == ST_ACCESS),
    .expired(expired)
  );

  assign timeout_hit = (state == ST_ACCESS) && !mem_moc && expired;

  // A new timeout beats a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_err <= 1'b0;
    end else if (timeout_hit) begin
      timeout_err <= 1'b1;
    end else if (err_clr) begin
      timeout_err <= 1'b0;
    end
  end
`else
  localparam int unused_cfg = TIMEOUT_CYCLES + CNT_W;
  logic unused_err_clr;

  assign unused_err_clr = err_clr;
  assign timeout_hit    = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  always_comb begin
    state_next = state;
    addr_sel   = 1'b0;
    mar_load   = 1'b0;
    mem_enable = 1'b0;
    mem_rw     = 1'b0;
    mdr_load   = 1'b0;
    ir_load    = 1'b0;
    fetch_done = 1'b0;
    data_done  = 1'b0;
    busy       = (state != ST_IDLE);

    unique case (state)
      ST_IDLE: begin
        if (data_req || fetch_req) state_next = ST_ADDR;
      end
      ST_ADDR: begin
        addr_sel   = owner;
        mar_load   = 1'b1;
        state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        addr_sel   = owner;
        mem_enable = 1'b1;
        mem_rw     = rw;
        if (mem_moc) begin
          state_next = (rw == RW_WRITE) ? ST_DONE : ST_CAPTURE;
        end else if (timeout_hit) begin
          state_next = ST_DONE;
        end
      end
      // RAM stays enabled so the read data is stable while it is captured.
      ST_CAPTURE: begin
        addr_sel   = owner;
        mem_enable = 1'b1;
        mdr_load   = (owner == OWNER_DATA);
        ir_load    = (owner == OWNER_FETCH);
        state_next = ST_DONE;
      end
      ST_DONE: begin
        addr_sel   = owner;
        fetch_done = (owner == OWNER_FETCH);
        data_done  = (owner == OWNER_DATA);
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_op_sequencer.sv
// Directed self-checking bench for mem_op_sequencer; timeout scenario follows MEM_SEQ_TIMEOUT_EN.
module tb_mem_op_sequencer;

  logic clk = 1'b0;
  logic reset;
  logic fetch_req, data_req, data_rw, mem_moc, err_clr;
  logic addr_sel, mar_load, mem_enable, mem_rw, mdr_load, ir_load;
  logic fetch_done, data_done, busy, timeout_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_op_sequencer #(.TIMEOUT_CYCLES(15), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_req  (fetch_req),
    .data_req   (data_req),
    .data_rw    (data_rw),
    .mem_moc    (mem_moc),
    .err_clr    (err_clr),
    .addr_sel   (addr_sel),
    .mar_load   (mar_load),
    .mem_enable (mem_enable),
    .mem_rw     (mem_rw),
    .mdr_load   (mdr_load),
    .ir_load    (ir_load),
    .fetch_done (fetch_done),
    .data_done  (data_done),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  // {timeout_err, addr_sel, mar_load, mem_enable, mem_rw, mdr_load, ir_load, fetch_done, data_done, busy}
  wire [9:0] obs = {timeout_err, addr_sel, mar_load, mem_enable, mem_rw,
                    mdr_load, ir_load, fetch_done, data_done, busy};

  localparam logic [9:0] V_IDLE   = 10'b0_0_0_0_0_0_0_0_0_0;
  localparam logic [9:0] V_F_ADDR = 10'b0_0_1_0_0_0_0_0_0_1;
  localparam logic [9:0] V_F_ACC  = 10'b0_0_0_1_0_0_0_0_0_1;
  localparam logic [9:0] V_F_CAP  = 10'b0_0_0_1_0_0_1_0_0_1;
  localparam logic [9:0] V_F_DONE = 10'b0_0_0_0_0_0_0_1_0_1;
  localparam logic [9:0] V_D_ADDR = 10'b0_1_1_0_0_0_0_0_0_1;
  localparam logic [9:0] V_D_RACC = 10'b0_1_0_1_0_0_0_0_0_1;
  localparam logic [9:0] V_D_WACC = 10'b0_1_0_1_1_0_0_0_0_1;
  localparam logic [9:0] V_D_CAP  = 10'b0_1_0_1_0_1_0_0_0_1;
  localparam logic [9:0] V_D_DONE = 10'b0_1_0_0_0_0_0_0_1_1;

  // Stimulus encoding per cycle: {fetch_req, data_req, data_rw, mem_moc}
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    {fetch_req, data_req, data_rw, mem_moc, err_clr} = '0;
    #3;
    total++;
    if (obs !== V_IDLE) begin
      bad++;
      $display("[TB] FAIL reset_async: got %b want %b", obs, V_IDLE);
    end
    tick();
    tick();
    total++;
    if (obs !== V_IDLE) begin
      bad++;
      $display("[TB] FAIL reset_held: got %b want %b", obs, V_IDLE);
    end
    reset = 1'b0;
    tick();
    total++;
    if (obs !== V_IDLE) begin
      bad++;
      $display("[TB] FAIL reset_release: got %b want %b", obs, V_IDLE);
    end
  endtask

  task automatic test_fetch();
    logic [3:0] stim [6];
    logic [9:0] expv [6];
    stim = '{4'b1000, 4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    expv = '{V_IDLE, V_F_ADDR, V_F_ACC, V_F_CAP, V_F_DONE, V_IDLE};
    for (int i = 0; i < 6; i++) begin
      {fetch_req, data_req, data_rw, mem_moc} = stim[i];
      #1;
      total++;
      if (obs !== expv[i]) begin
        bad++;
        $display("[TB] FAIL fetch c%0d: got %b want %b", i, obs, expv[i]);
      end
      tick();
    end
  endtask

  task automatic test_write_wait();
    logic [3:0] stim [7];
    logic [9:0] expv [7];
    stim = '{4'b0110, 4'b0101, 4'b0100, 4'b0100, 4'b0101, 4'b0000, 4'b0000};
    expv = '{V_IDLE, V_D_ADDR, V_D_WACC, V_D_WACC, V_D_WACC, V_D_DONE, V_IDLE};
    for (int i = 0; i < 7; i++) begin
      {fetch_req, data_req, data_rw, mem_moc} = stim[i];
      #1;
      total++;
      if (obs !== expv[i]) begin
        bad++;
        $display("[TB] FAIL write c%0d: got %b want %b", i, obs, expv[i]);
      end
      tick();
    end
  endtask

  task automatic test_priority();
    logic [3:0] stim [11];
    logic [9:0] expv [11];
    stim = '{4'b1100, 4'b1100, 4'b1101, 4'b1100, 4'b1000, 4'b1000,
             4'b1000, 4'b1001, 4'b1000, 4'b0000, 4'b0000};
    expv = '{V_IDLE, V_D_ADDR, V_D_RACC, V_D_CAP, V_D_DONE, V_IDLE,
             V_F_ADDR, V_F_ACC, V_F_CAP, V_F_DONE, V_IDLE};
    for (int i = 0; i < 11; i++) begin
      {fetch_req, data_req, data_rw, mem_moc} = stim[i];
      #1;
      total++;
      if (obs !== expv[i]) begin
        bad++;
        $display("[TB] FAIL priority c%0d: got %b want %b", i, obs, expv[i]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] stim [11];
    logic [9:0] expv [11];
    stim = '{4'b0100, 4'b0100, 4'b0101, 4'b0100, 4'b0100, 4'b0100,
             4'b0100, 4'b0101, 4'b0100, 4'b0000, 4'b0000};
    expv = '{V_IDLE, V_D_ADDR, V_D_RACC, V_D_CAP, V_D_DONE, V_IDLE,
             V_D_ADDR, V_D_RACC, V_D_CAP, V_D_DONE, V_IDLE};
    for (int i = 0; i < 11; i++) begin
      {fetch_req, data_req, data_rw, mem_moc} = stim[i];
      #1;
      total++;
      if (obs !== expv[i]) begin
        bad++;
        $display("[TB] FAIL b2b c%0d: got %b want %b", i, obs, expv[i]);
      end
      tick();
    end
  endtask

  task automatic test_spurious_moc();
    {fetch_req, data_req, data_rw, mem_moc} = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (obs !== V_IDLE) begin
        bad++;
        $display("[TB] FAIL spurious_idle c%0d: got %b want %b", i, obs, V_IDLE);
      end
      tick();
    end
    mem_moc = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    logic [3:0] stim [6];
    logic [9:0] expv [6];
    stim = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000};
    expv = '{V_IDLE, V_F_ADDR, V_F_ACC, V_F_ACC, V_IDLE, V_IDLE};
    for (int i = 0; i < 4; i++) begin
      {fetch_req, data_req, data_rw, mem_moc} = stim[i];
      #1;
      total++;
      if (obs !== expv[i]) begin
        bad++;
        $display("[TB] FAIL rst_pre c%0d: got %b want %b", i, obs, expv[i]);
      end
      tick();
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (obs !== V_IDLE) begin
      bad++;
      $display("[TB] FAIL rst_mid_async: got %b want %b", obs, V_IDLE);
    end
    tick();
    reset = 1'b0;
    stim = '{4'b1000, 4'b1000, 4'b1001, 4'b1000, 4'b0000, 4'b0000};
    expv = '{V_IDLE, V_F_ADDR, V_F_ACC, V_F_CAP, V_F_DONE, V_IDLE};
    for (int i = 0; i < 6; i++) begin
      {fetch_req, data_req, data_rw, mem_moc} = stim[i];
      #1;
      total++;
      if (obs !== expv[i]) begin
        bad++;
        $display("[TB] FAIL rst_restart c%0d: got %b want %b", i, obs, expv[i]);
      end
      tick();
    end
  endtask

`ifdef MEM_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    logic [9:0] expv;
    for (int i = 0; i < 20; i++) begin
      {fetch_req, data_req, data_rw, mem_moc} = (i <= 16) ? 4'b0100 : 4'b0000;
      err_clr = (i == 18);
      if (i == 0)       expv = V_IDLE;
      else if (i == 1)  expv = V_D_ADDR;
      else if (i <= 16) expv = V_D_RACC;
      else if (i == 17) expv = V_D_DONE | 10'b1000000000;
      else if (i == 18) expv = 10'b1000000000;
      else              expv = V_IDLE;
      #1;
      total++;
      if (obs !== expv) begin
        bad++;
        $display("[TB] FAIL timeout c%0d: got %b want %b", i, obs, expv);
      end
      tick();
    end
    err_clr = 1'b0;
  endtask
`else
  task automatic test_timeout();
    logic [9:0] expv;
    for (int i = 0; i < 26; i++) begin
      {fetch_req, data_req, data_rw, mem_moc} = (i == 22) ? 4'b0101 :
                                                (i <= 23) ? 4'b0100 : 4'b0000;
      err_clr = (i == 10);
      if (i == 0)       expv = V_IDLE;
      else if (i == 1)  expv = V_D_ADDR;
      else if (i <= 22) expv = V_D_RACC;
      else if (i == 23) expv = V_D_CAP;
      else if (i == 24) expv = V_D_DONE;
      else              expv = V_IDLE;
      #1;
      total++;
      if (obs !== expv) begin
        bad++;
        $display("[TB] FAIL no_timeout c%0d: got %b want %b", i, obs, expv);
      end
      tick();
    end
    err_clr = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_fetch();
    test_write_wait();
    test_priority();
    test_back_to_back();
    test_spurious_moc();
    test_reset_mid_access();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
